// File: rtl/wb_ram_arb2.sv
// Two-master Wishbone B3 round-robin arbiter in front of a single RAM slave.
// The grant is held for a whole cyc tenure, and a watchdog errors out accesses that stall.
module wb_ram_arb2 #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int timeout = 1024
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,

  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic [2:0]    m0_cti_i,
  input  logic [1:0]    m0_bte_i,
  output logic [dw-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic          m0_rty_o,

  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic [2:0]    m1_cti_i,
  input  logic [1:0]    m1_bte_i,
  output logic [dw-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          m1_rty_o,

  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic [2:0]    s_cti_o,
  output logic [1:0]    s_bte_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [dw-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic          s_rty_i
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ERR, DRAIN} state_t;

  localparam int WDW = (timeout > 0) ? $clog2(timeout + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (timeout > 0) ? WDW'(timeout - 1) : '0;

  state_t         r_state;
  state_t         w_nextState;
  logic           r_lastGnt;
  logic           w_nextLastGnt;
  logic [WDW-1:0] r_wdCnt;

  logic w_gnt;
  logic w_cyc;
  logic w_stb;
  logic w_resp;
  logic w_wdInc;
  logic w_wdFire;

  // last_gnt is updated at grant time, so it also names the owner during GNT/ERR/DRAIN.
  assign w_gnt    = (r_state == GNT0) || (r_state == GNT1);
  assign w_cyc    = r_lastGnt ? m1_cyc_i : m0_cyc_i;
  assign w_stb    = r_lastGnt ? m1_stb_i : m0_stb_i;
  assign w_resp   = s_ack_i | s_err_i | s_rty_i;
  assign w_wdInc  = (timeout > 0) && w_gnt && w_cyc && w_stb && !w_resp;
  assign w_wdFire = w_wdInc && (r_wdCnt == WD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= IDLE;
      r_lastGnt <= 1'b1;
      r_wdCnt   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_lastGnt <= w_nextLastGnt;
      r_wdCnt   <= (w_wdInc && !w_wdFire) ? r_wdCnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextLastGnt = r_lastGnt;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || r_lastGnt)) begin
          w_nextState   = GNT0;
          w_nextLastGnt = 1'b0;
        end else if (m1_cyc_i) begin
          w_nextState   = GNT1;
          w_nextLastGnt = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!w_cyc)
          w_nextState = IDLE;
        else if (w_wdFire)
          w_nextState = ERR;
      end
      ERR:     w_nextState = w_cyc ? DRAIN : IDLE;
      DRAIN:   if (!w_cyc) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  assign s_adr_o = r_lastGnt ? m1_adr_i : m0_adr_i;
  assign s_dat_o = r_lastGnt ? m1_dat_i : m0_dat_i;
  assign s_sel_o = r_lastGnt ? m1_sel_i : m0_sel_i;
  assign s_we_o  = r_lastGnt ? m1_we_i  : m0_we_i;
  assign s_cti_o = r_lastGnt ? m1_cti_i : m0_cti_i;
  assign s_bte_o = r_lastGnt ? m1_bte_i : m0_bte_i;
  assign s_cyc_o = w_gnt & w_cyc;
  assign s_stb_o = w_gnt & w_stb;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (r_state == GNT0) & s_ack_i;
  assign m1_ack_o = (r_state == GNT1) & s_ack_i;
  assign m0_rty_o = (r_state == GNT0) & s_rty_i;
  assign m1_rty_o = (r_state == GNT1) & s_rty_i;
  assign m0_err_o = ((r_state == GNT0) & s_err_i) | ((r_state == ERR) & !r_lastGnt);
  assign m1_err_o = ((r_state == GNT1) & s_err_i) | ((r_state == ERR) &  r_lastGnt);

endmodule

// File: tb/tb_wb_ram_arb2.sv
// Directed bench for wb_ram_arb2 with a 16-cycle watchdog and a combinational always-ready slave.
module tb_wb_ram_arb2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstN;

  logic [AW-1:0] m0Adr, m1Adr;
  logic [DW-1:0] m0DatW, m1DatW;
  logic [3:0]    m0Sel, m1Sel;
  logic          m0We, m1We, m0Cyc, m1Cyc, m0Stb, m1Stb;
  logic [2:0]    m0Cti, m1Cti;
  logic [1:0]    m0Bte, m1Bte;
  logic [DW-1:0] m0DatR, m1DatR;
  logic          m0Ack, m1Ack, m0Err, m1Err, m0Rty, m1Rty;

  logic [AW-1:0] sAdr;
  logic [DW-1:0] sDatW;
  logic [3:0]    sSel;
  logic          sWe, sCyc, sStb;
  logic [2:0]    sCti;
  logic [1:0]    sBte;
  logic [DW-1:0] sDatR;
  logic          sAck, sErr, sRty;
  logic          slaveAckEn;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  assign sAck = sStb & slaveAckEn;

  wb_ram_arb2 #(.dw(DW), .aw(AW), .timeout(TO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rstN),
    .m0_adr_i(m0Adr), .m0_dat_i(m0DatW), .m0_sel_i(m0Sel), .m0_we_i(m0We),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_cti_i(m0Cti), .m0_bte_i(m0Bte),
    .m0_dat_o(m0DatR), .m0_ack_o(m0Ack), .m0_err_o(m0Err), .m0_rty_o(m0Rty),
    .m1_adr_i(m1Adr), .m1_dat_i(m1DatW), .m1_sel_i(m1Sel), .m1_we_i(m1We),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_cti_i(m1Cti), .m1_bte_i(m1Bte),
    .m1_dat_o(m1DatR), .m1_ack_o(m1Ack), .m1_err_o(m1Err), .m1_rty_o(m1Rty),
    .s_adr_o(sAdr), .s_dat_o(sDatW), .s_sel_o(sSel), .s_we_o(sWe),
    .s_cti_o(sCti), .s_bte_o(sBte), .s_cyc_o(sCyc), .s_stb_o(sStb),
    .s_dat_i(sDatR), .s_ack_i(sAck), .s_err_i(sErr), .s_rty_i(sRty)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic cyc0, input logic stb0, input logic cyc1,
                               input logic stb1, input logic ackEn);
    @(posedge clk);
    #1;
    m0Cyc = cyc0; m0Stb = stb0; m1Cyc = cyc1; m1Stb = stb1; slaveAckEn = ackEn;
    @(negedge clk);
  endtask

  initial begin
    logic errSeen;
    logic cycLost;
    rstN = 1'b0;
    m0Adr = '0; m1Adr = '0; m0DatW = 32'h11111111; m1DatW = 32'h22222222;
    m0Sel = 4'hF; m1Sel = 4'hF; m0We = 1'b0; m1We = 1'b0;
    m0Cyc = 1'b0; m1Cyc = 1'b0; m0Stb = 1'b0; m1Stb = 1'b0;
    m0Cti = 3'b000; m1Cti = 3'b000; m0Bte = 2'b00; m1Bte = 2'b00;
    sDatR = 32'hDEADBEEF; sErr = 1'b0; sRty = 1'b0; slaveAckEn = 1'b1;

    @(negedge clk);
    checkOutput("rst_scyc", sCyc, 0);
    checkOutput("rst_sstb", sStb, 0);
    checkOutput("rst_resp", {m0Ack, m0Err, m0Rty, m1Ack, m1Err, m1Rty}, 0);
    @(posedge clk);
    #1 rstN = 1'b1;

    // Classic read from master 0 alone.
    m0Adr = 32'h10;
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t1_idle_scyc", sCyc, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t1_gnt_scyc", sCyc, 1);
    checkOutput("t1_adr", sAdr, 32'h10);
    checkOutput("t1_m0_ack", m0Ack, 1);
    checkOutput("t1_m0_dat", m0DatR, 32'hDEADBEEF);
    checkOutput("t1_m1_ack", m1Ack, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_drop_scyc", sCyc, 0);

    // Fresh reset, then ties and handover.
    @(posedge clk);
    #1 rstN = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;
    m0Adr = 32'h100; m1Adr = 32'h200;
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("t2_tie_scyc", sCyc, 1);
    checkOutput("t2_tie_adr", sAdr, 32'h100);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("t2_drop_scyc", sCyc, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("t2_idle_scyc", sCyc, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("t2_m1_scyc", sCyc, 1);
    checkOutput("t2_m1_adr", sAdr, 32'h200);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t2_m1drop_scyc", sCyc, 0);
    applyStimulus(1, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("t2_tie2_adr", sAdr, 32'h100);
    applyStimulus(0, 0, 0, 0, 1);

    // Master 1 runs an 8-beat incrementing burst while master 0 keeps requesting.
    applyStimulus(1, 1, 1, 1, 1);
    for (int beat = 0; beat < 8; beat++) begin
      @(posedge clk);
      #1;
      m1Adr = 32'h400 + 32'(beat * 4);
      m1Cti = (beat == 7) ? 3'b111 : 3'b010;
      @(negedge clk);
      checkOutput($sformatf("t3_m1_ack_%0d", beat), m1Ack, 1);
      checkOutput($sformatf("t3_m0_ack_%0d", beat), m0Ack, 0);
      checkOutput($sformatf("t3_adr_%0d", beat), sAdr, 32'h400 + 32'(beat * 4));
    end
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t3_drop_scyc", sCyc, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t3_idle_scyc", sCyc, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t3_m0_scyc", sCyc, 1);
    checkOutput("t3_m0_adr", sAdr, 32'h100);
    checkOutput("t3_m0_ack", m0Ack, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Slave never answers master 0: error in the 17th strobe cycle, then drain.
    m0Adr = 32'h800; m1Adr = 32'h900;
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("t4_stb", sStb, 1);
    errSeen = m0Err;
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1, 1, 1, 0, 0);
      errSeen |= m0Err;
    end
    checkOutput("t4_early_err", errSeen, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("t4_err", m0Err, 1);
    checkOutput("t4_err_scyc", sCyc, 0);
    checkOutput("t4_m1_err", m1Err, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("t4_drain_err", m0Err, 0);
    checkOutput("t4_drain_scyc", sCyc, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("t4_drain2_scyc", sCyc, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("t4_drop_scyc", sCyc, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("t4_idle_scyc", sCyc, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("t4_m1_scyc", sCyc, 1);
    checkOutput("t4_m1_adr", sAdr, 32'h900);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);

    // Ack lands exactly when the watchdog would fire; counter restarts afterwards.
    errSeen = 1'b0;
    cycLost = 1'b0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      errSeen |= m0Err;
      cycLost |= !sCyc;
    end
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("t5_ack", m0Ack, 1);
    checkOutput("t5_ack_err", m0Err, 0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      errSeen |= m0Err;
      cycLost |= !sCyc;
    end
    checkOutput("t5_no_err", errSeen, 0);
    checkOutput("t5_cyc_held", cycLost, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset mid-burst while master 1 waits; master 0 must win the following tie.
    m0Adr = 32'hA00;
    applyStimulus(1, 1, 0, 0, 1);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("t6_pre_ack", m0Ack, 1);
    applyStimulus(1, 1, 1, 0, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t6_rst_scyc", sCyc, 0);
    checkOutput("t6_rst_sstb", sStb, 0);
    checkOutput("t6_rst_ack", {m0Ack, m1Ack}, 0);
    @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    checkOutput("t6_idle_scyc", sCyc, 0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("t6_tie_scyc", sCyc, 1);
    checkOutput("t6_tie_adr", sAdr, 32'hA00);
    checkOutput("t6_tie_ack", m0Ack, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/wb_ram_arb2.md
Name: wb_ram_arb2

Overview:
Two-master Wishbone B3 arbiter that shares a single Wishbone slave (the on-chip RAM) between master 0 and master 1. It passes classic cycles and incrementing or constant bursts through unchanged. The grant is held for the whole wb_cyc_i tenure. Arbitration is round-robin, and a per-tenure watchdog terminates stalled accesses with an error.

Parameters:
dw, 32, data width
aw, 32, address width passed through unmodified
timeout, 1024, cycles with stb high and no ack before the watchdog fires; 0 disables the watchdog; counter width is clog2(timeout+1)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
mN_adr_i (N=0,1)  in  aw  master N address
mN_dat_i  in  dw  master N write data
mN_sel_i  in  4  master N byte selects
mN_we_i  in  1  master N write enable
mN_cyc_i  in  1  master N cycle (bus request)
mN_stb_i  in  1  master N strobe
mN_cti_i  in  3  master N cycle type
mN_bte_i  in  2  master N burst type
mN_dat_o  out  dw  read data to master N
mN_ack_o  out  1  ack to master N
mN_err_o  out  1  error to master N
mN_rty_o  out  1  retry to master N
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o  out  aw, dw, 4, 1, 3, 2  muxed request to the slave
s_cyc_o, s_stb_o  out  1  slave cycle and strobe, gated by grant
s_dat_i, s_ack_i, s_err_i, s_rty_i  in  dw, 1, 1, 1  slave response

Behaviour:
- States: IDLE, GNT0, GNT1, ERR, DRAIN. A last_gnt flag records the most recently granted master. The watchdog counter is wd_cnt.
- Reset (async, wb_rst_ni=0):
  - state=IDLE, last_gnt=1 so master 0 wins the first tie, wd_cnt=0.
  - All outputs read 0: s_cyc_o, s_stb_o, every mN_ack_o, mN_err_o, mN_rty_o.
  - Reset asserted mid-tenure aborts immediately. No ack or err is emitted for the aborted access.
- IDLE:
  - s_cyc_o=s_stb_o=0.
  - Exactly one mN_cyc_i high: go to GNTN next cycle.
  - Both high: grant the master != last_gnt.
  - Arbitration latency is one cycle: the first possible s_stb_o is the cycle after cyc is seen.
- GNTN:
  - All s_*_o come combinationally from master N; s_stb_o = mN_stb_i.
  - mN_ack_o, mN_err_o, mN_rty_o follow s_ack_i, s_err_i, s_rty_i.
  - mN_dat_o = s_dat_i.
  - The non-granted master sees ack, err and rty at 0. Its mN_dat_o also mirrors s_dat_i and is don't-care.
  - The grant is held regardless of cti, so bursts and back-to-back classic cycles stay uninterrupted.
  - mN_cyc_i=0: go to IDLE and set last_gnt=N. s_cyc_o drops in the same cycle because the mux is combinational.
  - Handover to the other master therefore costs exactly one IDLE cycle.
- Watchdog (timeout>0, state GNTN):
  - wd_cnt increments each cycle that mN_stb_i=1 and s_ack_i=s_err_i=s_rty_i=0.
  - It clears on any response, on stb=0, and on leaving GNTN.
  - When wd_cnt==timeout-1 and no response arrives that cycle, go to ERR.
- ERR:
  - For exactly one cycle: mN_err_o=1, s_cyc_o=s_stb_o=0, then go to DRAIN.
  - If mN_cyc_i is already 0 in ERR, go directly to IDLE.
- DRAIN:
  - s_cyc_o=0. The errored master is ignored until it drops cyc.
  - Then go to IDLE with last_gnt=N, so the other master gets priority.
- Simultaneous events:
  - A slave ack in the same cycle the watchdog would fire wins; the counter clears and no ERR occurs.
  - A request from the other master during GNTN or DRAIN waits.
- No buffering or registered data path: a granted access adds zero latency beyond the slave's own.

Test Plan:
- Only m0 issues a classic read to adr 0x10 → s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o equals s_ack_i; m0_dat_o = s_dat_i (0xDEADBEEF); m1_ack_o stays 0.
- m0 and m1 raise cyc in the same cycle out of reset → m0 granted. After m0 drops cyc: 1 IDLE cycle, then m1 granted. Next tie → m0 granted.
- m1 runs an 8-beat incrementing burst (cti 010…111, bte 00) while m0 requests throughout → all 8 acks go to m1 with no interruption; m0 is granted 2 cycles after m1 drops cyc.
- timeout=16, slave never acks m0's stb → m0_err_o pulses for 1 cycle in the 17th cycle after stb; s_cyc_o=0 in ERR and DRAIN; m1 is then granted first once m0 drops cyc.
- Slave ack arrives in the cycle wd_cnt=timeout-1 → normal ack, no err, counter cleared.
- wb_rst_ni pulsed low for 1 cycle mid-burst → s_cyc_o and all acks go to 0 asynchronously; state is IDLE; m0 wins the next tie.
